// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared encodings for the instruction fetch unit.
// Holds the FSM state encoding, the control-unit jump-kind encoding and the
// halt opcode used when the FETCH_HALT_EN build option is enabled.
package fetch_unit_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_ISSUE = 2'b01,
    ST_HALT  = 2'b10
  } fetch_state_e;

  // Encoding of the is_jump field driven by the control unit.
  typedef enum logic [1:0] {
    JMP_SEQ    = 2'b00,
    JMP_BRANCH = 2'b01,
    JMP_JUMP   = 2'b10,
    JMP_RSVD   = 2'b11
  } jump_kind_e;

  // Opcode that stops fetching when FETCH_HALT_EN is defined.
  localparam logic [3:0] OPC_HALT = 4'b1111;

  // Opcode field of an instruction word.
  function automatic logic [3:0] get_opcode(input logic [31:0] word);
    return word[31:28];
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// next_pc_sel: combinational next-PC selection for the fetch unit.
// Jumps and taken branches redirect to jump_target; every other case,
// including the reserved encoding, advances to pc+1 modulo 2^ADDR_W.
module next_pc_sel
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [1:0]        is_jump_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  output logic [ADDR_W-1:0] next_pc_o
);

  logic [ADDR_W-1:0] seq_pc_s;

  assign seq_pc_s = pc_i + ADDR_W'(1);

  // Select between the sequential successor and the redirect target.
  always_comb begin
    next_pc_o = seq_pc_s;
    case (jump_kind_e'(is_jump_i))
      JMP_JUMP: begin
        next_pc_o = jump_target_i;
      end
      JMP_BRANCH: begin
        if (branch_taken_i) begin
          next_pc_o = jump_target_i;
        end else begin
          next_pc_o = seq_pc_s;
        end
      end
      JMP_SEQ: begin
        next_pc_o = seq_pc_s;
      end
      default: begin
        next_pc_o = seq_pc_s;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a hand-off to decode.
// FETCH requests the word at pc, ISSUE holds it until decode retires it, and
// the retiring edge selects the next pc. Build option FETCH_HALT_EN: when
// defined, retiring opcode 4'b1111 parks the unit in HALT until reset; when
// undefined that opcode retires as a plain sequential instruction.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic [3:0]        opcode,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic [1:0]        is_jump,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [31:0]       inst_q;
  logic              inst_valid_q;
  logic              imem_req_q;
  logic              retire_halt_s;

  // Redirect inputs are only consumed on the retiring edge below.
  next_pc_sel #(
    .ADDR_W (ADDR_W)
  ) u_next_pc_sel (
    .pc_i           (pc_q),
    .is_jump_i      (is_jump),
    .branch_taken_i (branch_taken),
    .jump_target_i  (jump_target),
    .next_pc_o      (pc_d)
  );

`ifdef FETCH_HALT_EN
  logic halted_q;

  assign retire_halt_s = (get_opcode(inst_q) == OPC_HALT);
  assign halted        = halted_q;
`else
  assign retire_halt_s = 1'b0;
  assign halted        = 1'b0;
`endif

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign opcode     = get_opcode(inst_q);
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;

  // Fetch FSM; the request is raised one edge after entering FETCH so an ack
  // that lands on the first edge after reset cannot be mistaken for data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0000_0000;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_req_q && imem_ack) begin
            inst_q       <= imem_rdata;
            inst_valid_q <= 1'b1;
            imem_req_q   <= 1'b0;
            state_q      <= ST_ISSUE;
          end else begin
            imem_req_q   <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            if (retire_halt_s) begin
              imem_req_q <= 1'b0;
              state_q    <= ST_HALT;
`ifdef FETCH_HALT_EN
              halted_q   <= 1'b1;
`endif
            end else begin
              pc_q       <= pc_d;
              imem_req_q <= 1'b1;
              state_q    <= ST_FETCH;
            end
          end else begin
            inst_valid_q <= 1'b1;
          end
        end
        ST_HALT: begin
          imem_req_q   <= 1'b0;
          inst_valid_q <= 1'b0;
        end
        default: begin
          imem_req_q   <= 1'b0;
          inst_valid_q <= 1'b0;
          state_q      <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
// A memory/decode driver issues acks and retire decisions and pushes the
// expected (pc, inst) of every fetched word; a negedge monitor pops and
// compares whenever the DUT presents an instruction.
module tb_fetch_unit;

  localparam int AW = 32;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic [31:0]   inst;
  logic [3:0]    opcode;
  logic          inst_valid;
  logic          inst_ready;
  logic [1:0]    is_jump;
  logic          branch_taken;
  logic [AW-1:0] jump_target;
  logic [AW-1:0] pc;
  logic          halted;

  fetch_unit #(.ADDR_W(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .opcode       (opcode),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .is_jump      (is_jump),
    .branch_taken (branch_taken),
    .jump_target  (jump_target),
    .pc           (pc),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [1:0]  j;
    bit          tk;
    logic [31:0] tgt;
    int          hold;
  } dir_t;

  exp_t        exp_q[$];
  dir_t        dir_q[$];
  logic [31:0] retired_pcs[$];
  int          retire_cyc[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_retired = 0;

  logic [31:0] mdl_pc = 32'h0;
  logic [31:0] cur_inst = 32'h0;
  logic [31:0] halt_inst_pc = 32'h0;
  bit drv_en = 1'b0;
  bit rand_mode = 1'b0;
  bit tp_check = 1'b0;
  bit force_halt = 1'b0;
  bit halt_retired = 1'b0;
  bit first_done = 1'b0;
  int lat_max = 0;
  int first_lat = 2;
  int req_wait = -1;
  int hold_left = -1;

  // Architectural next-pc rule: jumps and taken branches redirect, else +1.
  function automatic logic [31:0] ref_next_pc(input logic [31:0] cur_pc, input logic [1:0] j,
                                              input bit tk, input logic [31:0] tgt);
    if (j == 2'b10 || (j == 2'b01 && tk)) return tgt;
    return cur_pc + 32'd1;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:28] == 4'hF) w[31] = 1'b0;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(posedge clk) cyc++;

  // Memory and decode driver: one decision per cycle, just after the edge.
  task automatic drive_cycle();
    logic [31:0] w;
    imem_ack     = 1'b0;
    inst_ready   = 1'b0;
    imem_rdata   = $urandom;
    is_jump      = 2'($urandom);
    branch_taken = 1'($urandom);
    jump_target  = $urandom;
    if (!drv_en || !rst_n) return;
    if (imem_req) begin
      if (req_wait < 0) req_wait = first_done ? int'($urandom_range(lat_max, 0)) : first_lat;
      if (req_wait == 0) begin
        w = force_halt ? 32'hF000_0000 : rand_word();
        imem_ack   = 1'b1;
        imem_rdata = w;
        exp_q.push_back('{pc: mdl_pc, inst: w});
        cur_inst   = w;
        req_wait   = -1;
        first_done = 1'b1;
      end else begin
        req_wait--;
      end
    end else if (inst_valid) begin
      if (rand_mode) imem_ack = 1'($urandom);
      if (force_halt && cur_inst == 32'hF000_0000) begin
        inst_ready = 1'b1;
        is_jump    = 2'b00;
      end else if (dir_q.size() > 0) begin
        if (hold_left < 0) hold_left = dir_q[0].hold;
        if (hold_left > 0) begin
          hold_left--;
        end else begin
          inst_ready   = 1'b1;
          is_jump      = dir_q[0].j;
          branch_taken = dir_q[0].tk;
          jump_target  = dir_q[0].tgt;
          void'(dir_q.pop_front());
          hold_left    = -1;
        end
      end else if (rand_mode) begin
        inst_ready = ($urandom_range(99, 0) < 60);
      end else begin
        inst_ready = 1'b1;
      end
      if (inst_ready) begin
        if (force_halt && cur_inst == 32'hF000_0000) begin
          halt_inst_pc = mdl_pc;
          halt_retired = 1'b1;
          force_halt   = 1'b0;
        end
        if (!(HALT_EN && cur_inst[31:28] == 4'hF))
          mdl_pc = ref_next_pc(mdl_pc, is_jump, branch_taken, jump_target);
      end
    end
  endtask

  initial begin
    imem_ack = 1'b0; inst_ready = 1'b0; imem_rdata = 32'h0;
    is_jump = 2'b00; branch_taken = 1'b0; jump_target = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      drive_cycle();
    end
  end

  // Monitor: scoreboard pops on each new instruction, plus protocol checks.
  initial begin
    bit   prev_valid;
    bit   expect_valid;
    exp_t cur;
    prev_valid = 1'b0;
    expect_valid = 1'b0;
    cur = '{pc: 32'h0, inst: 32'h0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        expect_valid = 1'b0;
        continue;
      end
      if (expect_valid) chk("ack_to_valid", 32'(inst_valid), 32'd1);
      expect_valid = imem_ack && imem_req;
      chk("req_valid_excl", 32'(imem_req & inst_valid), 32'd0);
      if (imem_req) chk("fetch_addr", imem_addr, mdl_pc);
      if (inst_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_inst");
          end else begin
            cur = exp_q.pop_front();
            chk("inst", inst, cur.inst);
            chk("opcode", 32'(opcode), 32'(cur.inst[31:28]));
            chk("inst_pc", pc, cur.pc);
          end
        end else begin
          chk("hold_inst", inst, cur.inst);
          chk("hold_pc", pc, cur.pc);
        end
        if (inst_ready) begin
          retired_pcs.push_back(pc);
          retire_cyc.push_back(cyc);
          n_retired++;
          if (tp_check && retire_cyc.size() >= 2 && retire_cyc.size() <= 4)
            chk("throughput", 32'(retire_cyc[retire_cyc.size()-1] - retire_cyc[retire_cyc.size()-2]), 32'd2);
        end
      end
      prev_valid = inst_valid && !inst_ready;
    end
  end

  // Directed phases, then random traffic, then the halt-opcode case.
  initial begin
    logic [31:0] exp_pcs [12];
    int base;
    bit seen;
    exp_pcs = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h40,
                32'h10, 32'h11, 32'hFFFF_FFFF, 32'h0};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);

    for (int i = 0; i < 5; i++) dir_q.push_back('{j: 2'b00, tk: 1'b0, tgt: 32'h0, hold: 0});
    dir_q.push_back('{j: 2'b01, tk: 1'b0, tgt: 32'h99, hold: 0});
    dir_q.push_back('{j: 2'b01, tk: 1'b1, tgt: 32'h40, hold: 0});
    dir_q.push_back('{j: 2'b10, tk: 1'b0, tgt: 32'h10, hold: 0});
    dir_q.push_back('{j: 2'b00, tk: 1'b1, tgt: 32'h77, hold: 5});
    dir_q.push_back('{j: 2'b10, tk: 1'b0, tgt: 32'hFFFF_FFFF, hold: 0});
    dir_q.push_back('{j: 2'b00, tk: 1'b1, tgt: 32'h55, hold: 0});
    dir_q.push_back('{j: 2'b00, tk: 1'b0, tgt: 32'h0, hold: 0});
    mdl_pc = 32'h0;
    tp_check = 1'b1;
    lat_max = 0;
    drv_en = 1'b1;
    rst_n = 1'b1;

    for (int i = 0; i < 400 && n_retired < 12; i++) @(posedge clk);
    #2;
    tp_check = 1'b0;
    if (n_retired < 12) fail_now("timeout_directed");
    for (int i = 0; i < 12 && i < retired_pcs.size(); i++) chk("directed_pc", retired_pcs[i], exp_pcs[i]);

    // Reset in the middle of a fetch, with an ack arriving after release.
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #2;
      seen = imem_req;
    end
    if (!seen) fail_now("timeout_wait_req");
    rst_n = 1'b0;
    drv_en = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("mid_rst_imem_req", 32'(imem_req), 32'd0);
    chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_inst", inst, 32'h0);
    exp_q.delete();
    dir_q.delete();
    mdl_pc = 32'h0;
    req_wait = -1;
    hold_left = -1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #2;
    chk("late_ack_inst_valid", 32'(inst_valid), 32'd0);
    chk("late_ack_inst", inst, 32'h0);
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", imem_addr, 32'h0);
    lat_max = 3;
    rand_mode = 1'b1;
    drv_en = 1'b1;

    base = n_retired;
    for (int i = 0; i < 6000 && n_retired < base + 300; i++) @(posedge clk);
    #2;
    if (n_retired < base + 300) fail_now("timeout_random");

    // Halt opcode: parks the unit when enabled, retires sequentially otherwise.
    force_halt = 1'b1;
    for (int i = 0; i < 200 && !halt_retired; i++) begin
      @(posedge clk);
      #2;
    end
    if (!halt_retired) begin
      fail_now("timeout_halt");
    end else begin
      @(posedge clk);
      #2;
      if (HALT_EN) begin
        for (int i = 0; i < 20; i++) begin
          chk("halt_halted", 32'(halted), 32'd1);
          chk("halt_req", 32'(imem_req), 32'd0);
          chk("halt_valid", 32'(inst_valid), 32'd0);
          chk("halt_pc", pc, halt_inst_pc);
          @(posedge clk);
          #2;
        end
      end else begin
        chk("nohalt_pc", pc, halt_inst_pc + 32'd1);
        chk("nohalt_req", 32'(imem_req), 32'd1);
        for (int i = 0; i < 20; i++) begin
          chk("nohalt_halted", 32'(halted), 32'd0);
          @(posedge clk);
          #2;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32: PC and instruction-memory word-address width.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  ADDR_W  word address of the requested instruction.
REQ-007 imem_ack  input  1  memory has returned data on imem_rdata this cycle.
REQ-008 imem_rdata  input  32  instruction word from memory.
REQ-009 inst  output  32  held instruction word.
REQ-010 opcode  output  4  inst[31:28]; feeds the control unit.
REQ-011 inst_valid  output  1  inst/opcode valid for decode.
REQ-012 inst_ready  input  1  decode/execute retires the held instruction this cycle.
REQ-013 is_jump  input  2  from control unit: 00 sequential, 01 conditional branch, 10 unconditional jump, 11 reserved.
REQ-014 branch_taken  input  1  branch condition result; used only when is_jump=01.
REQ-015 jump_target  input  ADDR_W  target for a taken branch or a jump.
REQ-016 pc  output  ADDR_W  address of the held or currently fetched instruction.
REQ-017 halted  output  1  fetch has stopped on a halt instruction.

Function
REQ-018 FSM states SHALL be FETCH, ISSUE and HALT; reset state SHALL be FETCH.
REQ-019 FETCH: imem_req=1 and imem_addr=pc; on imem_ack the block SHALL capture imem_rdata into inst and go to ISSUE on the next edge.
REQ-020 imem_addr SHALL remain stable while imem_req=1; imem_ack outside FETCH SHALL be ignored.
REQ-021 ISSUE: inst_valid=1, imem_req=0; inst, opcode and pc SHALL stay stable until inst_ready=1.
REQ-022 is_jump, branch_taken and jump_target SHALL be sampled only on the ISSUE cycle with inst_ready=1.
REQ-023 Next PC: 10 -> jump_target; 01 with branch_taken=1 -> jump_target; otherwise (00, 01 not taken, 11) -> pc+1, wrapping modulo 2^ADDR_W.
REQ-024 On the retiring edge, pc SHALL update and the state SHALL return to FETCH (or go to HALT per REQ-029).
REQ-025 Minimum throughput SHALL be one instruction per 2 cycles (ack in the first FETCH cycle, ready in the first ISSUE cycle).
REQ-026 inst_valid and imem_req SHALL never be asserted in the same cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force: state FETCH, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, halted=0; imem_req SHALL assert in the first cycle after release.
REQ-028 Reset asserted mid-fetch or mid-issue SHALL abandon the transaction; a late imem_ack SHALL NOT be captured.

Configuration
REQ-029 With FETCH_HALT_EN defined, retiring opcode 4'b1111 SHALL move to HALT (pc unchanged, halted=1, imem_req=0, inst_valid=0) until reset; without it, 4'b1111 SHALL retire as sequential and halted SHALL be tied 0.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the is_jump encodings (00/01/10/11), and OPC_HALT=4'b1111.
REQ-031 The next-PC selection SHALL be a sub-module, next_pc_sel (combinational).

Verification
REQ-032 Reset release with RESET_PC=0, memory acking after 2 cycles -> imem_req at addr 0, ack captured, inst_valid=1 one cycle later, opcode=inst[31:28].
REQ-033 Sequential stream with inst_ready held 1, zero-wait memory -> pc 0,1,2,3 on successive retirements, exactly 2 cycles each.
REQ-034 is_jump=01, branch_taken=0, then is_jump=01, branch_taken=1, jump_target=0x40 -> pc goes 5->6, then 6->0x40; is_jump=10, jump_target=0x10 -> pc=0x10.
REQ-035 inst_ready held 0 for 5 cycles -> inst, opcode, pc stable, imem_req=0 throughout; pc=0xFFFFFFFF with is_jump=00 retiring -> pc wraps to 0.
REQ-036 rst_n pulsed low during FETCH with ack arriving after release -> no capture, pc=RESET_PC, new fetch issued.
REQ-037 FETCH_HALT_EN defined, inst=0xF0000000 retired -> halted=1, imem_req stays 0 for 20 cycles; macro undefined -> pc increments, halted=0.
